sram_port_ctrl_128x64: RTL and testbench

- Initiator-side controller for one port of the 128x64 byte-writable SRAM macro wrapper.
- Converts a valid/ready request stream (read or byte-masked write) into the macro's active-low CEB/WEB/BWEB strobes.
- Captures the macro's 1-cycle-latency read data into a small response FIFO with backpressure.
- Optionally zero-fills the whole array after reset; sits between cache/scratchpad logic and the RAM wrapper.

---
 rtl/sram_port_ctrl_128x64.sv | 142 ++++++++++++++
 tb/tb_sram_port_ctrl_128x64.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_ctrl_128x64.sv
// Request-side controller for one port of the 128x64 byte-writable SRAM wrapper:
// valid/ready requests in, active-low macro strobes out, read data buffered in a credit-managed FIFO.
module sram_port_ctrl_128x64 #(
    parameter int CLEAR_ON_RESET = 1,
    parameter int RSPDEPTH       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [6:0]  ReqAdr,
    input  logic [63:0] ReqData,
    input  logic [7:0]  ReqByteEn,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [63:0] RspData,
    output logic        InitDone,
    output logic        CEB,
    output logic        WEB,
    output logic [6:0]  A,
    output logic [63:0] D,
    output logic [63:0] BWEB,
    input  logic [63:0] Q
);

    localparam int PW = (RSPDEPTH > 1) ? $clog2(RSPDEPTH) : 1;
    localparam int CW = $clog2(RSPDEPTH + 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
    localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    logic [0:0]    r_state;
    logic [6:0]    r_clr_cnt;
    logic          r_rd_in_flight;
    logic [63:0]   r_fifo [RSPDEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_init_done;
    logic          w_clearing;
    logic          w_pop;
    logic          w_issue;
    logic [CW:0]   w_occupancy;
    logic [63:0]   w_bit_mask;

    function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(RSPDEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    // Reset gates the outputs combinationally so the macro is idle the instant reset rises.
    assign w_init_done = (r_state == ST_READY) & ~reset;
    assign w_clearing  = (r_state == ST_CLEAR) & ~reset;

    assign RspValid    = (r_count != '0);
    assign RspData     = r_fifo[r_rd_ptr];
    assign InitDone    = w_init_done;
    assign w_pop       = RspValid & RspReady;

    // A slot is reserved for every outstanding read, so the FIFO cannot overflow.
    assign w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_rd_in_flight};
    assign ReqReady    = w_init_done & ((w_occupancy < (CW+1)'(RSPDEPTH)) | w_pop);
    assign w_issue     = ReqValid & ReqReady;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_bit_mask[8*i +: 8] = {8{ReqByteEn[i]}};
        end
    end

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        CEB  = 1'b1;
        WEB  = 1'b1;
        BWEB = '1;
        A    = ReqAdr;
        D    = ReqData;
        if (reset) begin
            A = '0;
            D = '0;
        end else if (w_clearing) begin
            CEB  = 1'b0;
            WEB  = 1'b0;
            BWEB = '0;
            A    = r_clr_cnt;
            D    = '0;
        end else if (w_issue) begin
            CEB = 1'b0;
            if (ReqWrite) begin
                WEB  = 1'b0;
                BWEB = ~w_bit_mask;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_RESET;
            r_clr_cnt      <= '0;
            r_rd_in_flight <= 1'b0;
        end else begin
            r_rd_in_flight <= w_issue & ~ReqWrite;
            if (r_state == ST_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 7'd1;
                if (r_clr_cnt == 7'd127) begin
                    r_state <= ST_READY;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (r_rd_in_flight) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            r_count <= r_count + CW'(r_rd_in_flight) - CW'(w_pop);
        end
    end

    // NOTE: the tiny FIFO storage is reset on purpose so RspData reads zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RSPDEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else if (r_rd_in_flight) begin
            r_fifo[r_wr_ptr] <= Q;
        end
    end

endmodule

// File: tb/tb_sram_port_ctrl_128x64.sv
// Directed bench for sram_port_ctrl_128x64 with a behavioural model of the byte-writable macro.
module tb_sram_port_ctrl_128x64;

    logic        clk = 1'b0;
    logic        reset;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [6:0]  ReqAdr;
    logic [63:0] ReqData;
    logic [7:0]  ReqByteEn;
    logic        RspValid;
    logic        RspReady;
    logic [63:0] RspData;
    logic        InitDone;
    logic        CEB;
    logic        WEB;
    logic [6:0]  A;
    logic [63:0] D;
    logic [63:0] BWEB;
    logic [63:0] q_reg = '0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_port_ctrl_128x64 dut (
        .clk       (clk),
        .reset     (reset),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .ReqWrite  (ReqWrite),
        .ReqAdr    (ReqAdr),
        .ReqData   (ReqData),
        .ReqByteEn (ReqByteEn),
        .RspValid  (RspValid),
        .RspReady  (RspReady),
        .RspData   (RspData),
        .InitDone  (InitDone),
        .CEB       (CEB),
        .WEB       (WEB),
        .A         (A),
        .D         (D),
        .BWEB      (BWEB),
        .Q         (q_reg)
    );

    // Macro model: non-zero power-up contents so the clear sweep is observable.
    logic [63:0] mem [128] = '{default: 64'hA5A5_5A5A_F00D_CAFE};

    always @(posedge clk) begin
        if (!CEB) begin
            if (!WEB) mem[A] <= (mem[A] & BWEB) | (D & ~BWEB);
            else      q_reg  <= mem[A];
        end
    end

    function automatic logic [63:0] pat(input int k);
        return 64'hC0DE_0000_0000_0000 | 64'(k);
    endfunction

    // Called and returns at a falling edge; leaves ReqValid high.
    task automatic issue(input logic wr, input logic [6:0] adr, input logic [63:0] data,
                         input logic [7:0] be);
        ReqValid = 1'b1; ReqWrite = wr; ReqAdr = adr; ReqData = data; ReqByteEn = be;
        #1;
        for (int i = 0; i < 20 && ReqReady !== 1'b1; i++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (ReqReady !== 1'b1) begin
            failures++;
            $display("FAIL issue_accept adr=%0d ReqReady=%b required 1", adr, ReqReady);
        end
        @(negedge clk);
    endtask

    task automatic read_one(input logic [6:0] adr, output logic [63:0] data);
        issue(1'b0, adr, '0, '0);
        ReqValid = 1'b0;
        data = 'x;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (RspValid === 1'b1) begin
                data = RspData;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAdr = '0; ReqData = '0;
        ReqByteEn = '0; RspReady = 1'b1;
        #1;
        checks++;
        if ({CEB, WEB, BWEB, A, D, ReqReady, RspValid, RspData, InitDone} !==
            {1'b1, 1'b1, {64{1'b1}}, 7'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values CEB=%b WEB=%b BWEB=%h A=%0d D=%h RR=%b RV=%b RD=%h ID=%b required 1 1 all-ones 0 0 0 0 0 0",
                     CEB, WEB, BWEB, A, D, ReqReady, RspValid, RspData, InitDone);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 128; k++) begin
            #1;
            checks++;
            if (CEB !== 1'b0 || WEB !== 1'b0 || BWEB !== 64'd0 || D !== 64'd0 ||
                A !== 7'(k) || ReqReady !== 1'b0 || InitDone !== 1'b0) begin
                failures++;
                $display("FAIL sweep_cycle_%0d CEB=%b WEB=%b BWEB=%h D=%h A=%0d RR=%b ID=%b required 0 0 0 0 %0d 0 0",
                         k, CEB, WEB, BWEB, D, A, ReqReady, InitDone, k);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (InitDone !== 1'b1 || ReqReady !== 1'b1 || CEB !== 1'b1) begin
            failures++;
            $display("FAIL sweep_done InitDone=%b ReqReady=%b CEB=%b required 1 1 1",
                     InitDone, ReqReady, CEB);
        end
        @(negedge clk);
    endtask

    task automatic test_clear_readback;
        logic [63:0] got;
        logic [6:0]  adrs [3] = '{7'd0, 7'd64, 7'd127};
        for (int i = 0; i < 3; i++) begin
            read_one(adrs[i], got);
            checks++;
            if (got !== 64'd0) begin
                failures++;
                $display("FAIL clear_read adr=%0d got=%h required 0", adrs[i], got);
            end
        end
    endtask

    task automatic test_byte_write;
        logic [63:0] got;
        issue(1'b1, 7'd5, 64'h1122_3344_5566_7788, 8'hFF);
        ReqWrite = 1'b1; ReqAdr = 7'd5; ReqData = 64'hAAAA_AAAA_AAAA_AAAA; ReqByteEn = 8'h0F;
        #1;
        checks++;
        if (ReqReady !== 1'b1 || CEB !== 1'b0 || WEB !== 1'b0 || A !== 7'd5 ||
            D !== 64'hAAAA_AAAA_AAAA_AAAA || BWEB !== 64'hFFFF_FFFF_0000_0000) begin
            failures++;
            $display("FAIL partial_write_strobes RR=%b CEB=%b WEB=%b A=%0d D=%h BWEB=%h required 1 0 0 5 aaaaaaaaaaaaaaaa ffffffff00000000",
                     ReqReady, CEB, WEB, A, D, BWEB);
        end
        @(negedge clk);
        issue(1'b1, 7'd5, 64'd0, 8'h00);
        ReqValid = 1'b0;
        read_one(7'd5, got);
        checks++;
        if (got !== 64'h1122_3344_AAAA_AAAA) begin
            failures++;
            $display("FAIL byte_merge got=%h required 11223344aaaaaaaa", got);
        end
    endtask

    task automatic test_back_to_back;
        for (int k = 1; k <= 8; k++) issue(1'b1, 7'(k), pat(k), 8'hFF);
        ReqValid = 1'b0;
        RspReady = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                ReqValid = 1'b1; ReqWrite = 1'b0; ReqAdr = 7'(c + 1);
            end else begin
                ReqValid = 1'b0;
            end
            #1;
            if (c < 8) begin
                checks++;
                if (ReqReady !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready cycle=%0d ReqReady=%b required 1", c, ReqReady);
                end
            end
            checks++;
            if (c >= 2 && c < 10) begin
                if (RspValid !== 1'b1 || RspData !== pat(c - 1)) begin
                    failures++;
                    $display("FAIL b2b_rsp cycle=%0d RspValid=%b RspData=%h required 1 %h",
                             c, RspValid, RspData, pat(c - 1));
                end
            end else if (RspValid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_norsp cycle=%0d RspValid=%b required 0", c, RspValid);
            end
            if (c == 9) begin
                checks++;
                if (CEB !== 1'b1 || WEB !== 1'b1 || BWEB !== '1) begin
                    failures++;
                    $display("FAIL idle_strobes CEB=%b WEB=%b BWEB=%h required 1 1 all-ones",
                             CEB, WEB, BWEB);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        logic        exp_rr [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        RspReady = 1'b0;
        ReqValid = 1'b1; ReqWrite = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c < 3) ReqAdr = 7'(c + 1);
            #1;
            checks++;
            if (ReqReady !== exp_rr[c]) begin
                failures++;
                $display("FAIL bp_ready cycle=%0d ReqReady=%b required %b", c, ReqReady, exp_rr[c]);
            end
            if (c == 3) begin
                checks++;
                if (RspValid !== 1'b1 || RspData !== pat(1)) begin
                    failures++;
                    $display("FAIL bp_held RspValid=%b RspData=%h required 1 %h", RspValid, RspData, pat(1));
                end
            end
            @(negedge clk);
        end
        RspReady = 1'b1;
        #1;
        checks++;
        if (ReqReady !== 1'b1 || RspValid !== 1'b1 || RspData !== pat(1)) begin
            failures++;
            $display("FAIL bp_release RR=%b RV=%b RD=%h required 1 1 %h", ReqReady, RspValid, RspData, pat(1));
        end
        @(negedge clk);
        ReqValid = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            #1;
            checks++;
            if (c < 4 && (RspValid !== 1'b1 || RspData !== pat(c))) begin
                failures++;
                $display("FAIL bp_drain idx=%0d RV=%b RD=%h required 1 %h", c, RspValid, RspData, pat(c));
            end else if (c == 4 && RspValid !== 1'b0) begin
                failures++;
                $display("FAIL bp_empty RspValid=%b required 0", RspValid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_write_then_read;
        logic [63:0] got = 'x;
        issue(1'b1, 7'd9, 64'hDEAD, 8'hFF);
        ReqWrite = 1'b0; ReqAdr = 7'd9;
        #1;
        checks++;
        if (ReqReady !== 1'b1 || CEB !== 1'b0 || WEB !== 1'b1 || BWEB !== '1 || A !== 7'd9) begin
            failures++;
            $display("FAIL read_strobes RR=%b CEB=%b WEB=%b BWEB=%h A=%0d required 1 0 1 all-ones 9",
                     ReqReady, CEB, WEB, BWEB, A);
        end
        @(negedge clk);
        ReqValid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (RspValid === 1'b1) begin
                got = RspData;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (got !== 64'hDEAD) begin
            failures++;
            $display("FAIL raw_read got=%h required dead", got);
        end
    endtask

    task automatic wait_init(input string tag);
        for (int i = 0; i < 200 && InitDone !== 1'b1; i++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (InitDone !== 1'b1) begin
            failures++;
            $display("FAIL %s_init_timeout InitDone=%b required 1", tag, InitDone);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midop;
        int          stale = 0;
        logic [63:0] got;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        checks++;
        if (A !== 7'd40 || CEB !== 1'b0) begin
            failures++;
            $display("FAIL mid_sweep A=%0d CEB=%b required 40 0", A, CEB);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (CEB !== 1'b1 || RspValid !== 1'b0 || A !== 7'd0) begin
            failures++;
            $display("FAIL sweep_async_reset CEB=%b RspValid=%b A=%0d required 1 0 0", CEB, RspValid, A);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (A !== 7'd0 || CEB !== 1'b0) begin
            failures++;
            $display("FAIL sweep_restart A=%0d CEB=%b required 0 0", A, CEB);
        end
        wait_init("sweep");

        RspReady = 1'b0;
        issue(1'b0, 7'd1, '0, '0);
        issue(1'b0, 7'd2, '0, '0);
        ReqValid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (RspValid !== 1'b1) begin
            failures++;
            $display("FAIL buffered_before_reset RspValid=%b required 1", RspValid);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (RspValid !== 1'b0 || CEB !== 1'b1 || RspData !== 64'd0 || ReqReady !== 1'b0) begin
            failures++;
            $display("FAIL buffered_async_reset RV=%b CEB=%b RD=%h RR=%b required 0 1 0 0",
                     RspValid, CEB, RspData, ReqReady);
        end
        @(negedge clk);
        reset = 1'b0;
        RspReady = 1'b1;
        #1;
        checks++;
        if (A !== 7'd0 || CEB !== 1'b0) begin
            failures++;
            $display("FAIL buffered_restart A=%0d CEB=%b required 0 0", A, CEB);
        end
        for (int i = 0; i < 140; i++) begin
            @(negedge clk); #1;
            if (RspValid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0 || InitDone !== 1'b1) begin
            failures++;
            $display("FAIL no_stale_rsp stale_cycles=%0d InitDone=%b required 0 1", stale, InitDone);
        end
        @(negedge clk);
        read_one(7'd1, got);
        checks++;
        if (got !== 64'd0) begin
            failures++;
            $display("FAIL post_reset_read got=%h required 0", got);
        end
    endtask

    initial begin
        test_reset();
        test_clear_readback();
        test_byte_write();
        test_back_to_back();
        test_backpressure();
        test_write_then_read();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
